// File: rtl/resp_misr_checker_if.sv
// Host-side bundle for resp_misr_checker.
//   master : host / stimulus side. Drives start, resp_valid, resp_data and golden_sig.
//            Observes busy, done, pass, timeout, signature and vec_count.
//   slave  : the checker itself (directions reversed).
interface resp_misr_checker_if #(
  parameter int OUT_WIDTH = 7,
  parameter int SIG_WIDTH = 16
);
  logic                 start;
  logic                 resp_valid;
  logic [OUT_WIDTH-1:0] resp_data;
  logic [SIG_WIDTH-1:0] golden_sig;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic [SIG_WIDTH-1:0] signature;
  logic [15:0]          vec_count;

  modport master (
    output start, resp_valid, resp_data, golden_sig,
    input  busy, done, pass, timeout, signature, vec_count
  );

  modport slave (
    input  start, resp_valid, resp_data, golden_sig,
    output busy, done, pass, timeout, signature, vec_count
  );
endinterface

// File: rtl/resp_misr_checker.sv
// resp_misr_checker: compacts a fixed-length run of DUT response vectors into a
// MISR signature, then compares the signature against a golden value.
// A watchdog aborts a run whose response stream stalls.
//   clk, rst_n     : single clock, asynchronous active-low reset
//   bus.start      : pulse; begins or restarts a run from any state
//   bus.resp_valid : resp_data carries a response vector this cycle
//   bus.golden_sig : expected signature, sampled in CHECK
//   bus.busy       : high in RUN and CHECK
//   bus.done       : high in DONE; pass, timeout, signature and vec_count are final
//   bus.signature  : current MISR value
//   bus.vec_count  : vectors accepted in the current or last run
module resp_misr_checker #(
  parameter int                   OUT_WIDTH  = 7,
  parameter int                   SIG_WIDTH  = 16,
  parameter int                   VEC_LENGTH = 8,
  parameter logic [SIG_WIDTH-1:0] POLY       = SIG_WIDTH'(32'h100B),
  parameter logic [SIG_WIDTH-1:0] SEED       = SIG_WIDTH'(32'hFFFF),
  parameter int                   TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  resp_misr_checker_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The watchdog only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int              WD_W     = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [15:0]     LAST_IDX = 16'(VEC_LENGTH - 1);

  logic [1:0]           state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [SIG_WIDTH-1:0] misr_next;

  always_comb begin
    // Shift left, fold the outgoing MSB back through the polynomial, then
    // inject the (zero-extended) response vector.
    misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
              ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
              ^ SIG_WIDTH'(bus.resp_data);

    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    // start restarts from any state and beats a same-cycle resp_valid.
    if (bus.start) begin
      state_d   = S_RUN;
      sig_d     = SEED;
      cnt_d     = '0;
      wd_d      = '0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.resp_valid) begin
            // A valid on the watchdog's last cycle still counts.
            sig_d = misr_next;
            cnt_d = cnt_q + 16'd1;
            wd_d  = '0;
            if (cnt_q == LAST_IDX) state_d = S_CHECK;
          end else if (wd_q == WD_MAX) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        S_CHECK: begin
          pass_d  = (sig_q == bus.golden_sig);
          state_d = S_DONE;
        end
        default: ;  // IDLE waits for start, DONE holds results
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sig_q     <= SEED;
      cnt_q     <= '0;
      wd_q      <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_CHECK);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.timeout   = timeout_q;
  assign bus.signature = sig_q;
  assign bus.vec_count = cnt_q;

endmodule

// File: doc/resp_misr_checker.md
# resp_misr_checker

Synthesizable response-side companion to the c432 stimulus path. It captures the DUT's primary-output vector each applied cycle and compacts a fixed-length run into a MISR signature. At end of run it compares the signature against a golden value and reports pass/fail, with a watchdog that flags a stalled response stream. It sits between the c432 outputs (N223…N432, packed MSB-first) and the experiment host, replacing per-vector file dumps for long aging runs.

## Interface
- OUT_WIDTH, 7: width of the DUT output vector (c432: N223,N329,N370,N421,N430,N431,N432 → bits 6..0).
- SIG_WIDTH, 16: MISR / signature width; must be ≥ OUT_WIDTH.
- VEC_LENGTH, 8: number of response vectors per run; 1..65535.
- POLY, 16'h100B: MISR feedback polynomial (x^16+x^12+x^3+x+1), low SIG_WIDTH bits used.
- SEED, 16'hFFFF: MISR initial value loaded at run start.
- TIMEOUT, 1024: idle cycles in RUN without resp_valid before timeout; ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin (or restart) a run.
- resp_valid  in  1  resp_data holds a response vector this cycle.
- resp_data  in  OUT_WIDTH  DUT output vector.
- golden_sig  in  SIG_WIDTH  expected signature; sampled in CHECK.
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE; results valid.
- pass  out  1  signature matched golden_sig (only meaningful with done).
- timeout  out  1  run aborted by watchdog.
- signature  out  SIG_WIDTH  current MISR value.
- vec_count  out  16  response vectors accepted in current/last run.

## Operation
- States: IDLE, RUN, CHECK, DONE. Reset → IDLE; busy=0, done=0, pass=0, timeout=0, signature=SEED, vec_count=0, watchdog=0.
- IDLE: start → RUN, load signature=SEED, vec_count=0, watchdog=0, clear pass/timeout. resp_valid ignored.
- RUN, accepted vector (resp_valid=1): signature ← {signature[SIG_WIDTH-2:0],1'b0} ^ (signature[SIG_WIDTH-1] ? POLY : 0) ^ zero-extended resp_data; vec_count+1; watchdog ← 0. If this is vector number VEC_LENGTH (vec_count was VEC_LENGTH-1) → CHECK.
- RUN, no valid: watchdog+1; when watchdog reaches TIMEOUT-1 and still no valid → DONE with timeout=1, pass=0. A valid on that same cycle wins (accepted, no timeout).
- CHECK (one cycle, resp_valid ignored): pass ← (signature == golden_sig); → DONE.
- DONE: done=1; signature, vec_count, pass, timeout held. resp_valid ignored. start → RUN (new run).
- start in RUN or CHECK: abort and restart exactly as from IDLE; done stays 0. start has priority over resp_valid the same cycle (vector discarded).
- rst_n low at any time: immediate return to reset values; run lost.
- vec_count is 16 bits; never exceeds VEC_LENGTH.

## Timing
- Vector accepted at posedge where state==RUN and resp_valid=1; signature/vec_count visible next cycle.
- Final vector accepted at edge N → state CHECK during cycle N..N+1 → done/pass registered at edge N+1 (2 edges after the last valid is presented at N-… i.e. done high the cycle after CHECK).
- Start pulse at edge S → busy=1 from edge S; first vector accepted no earlier than edge S+1.
- Back-to-back valids every cycle supported; no backpressure (no ready).
- Timeout: with no valids after entering RUN, done=timeout=1 after TIMEOUT edges in RUN.

## Test plan
- Reset: assert rst_n=0 mid-RUN → next cycle busy=0, done=0, signature=16'hFFFF, vec_count=0.
- SEED=0, VEC_LENGTH=2, POLY default: start, valids 7'h05 then 7'h03, golden_sig=16'h0009 → signature 16'h0005 then 16'h0009; done=1, pass=1, vec_count=2; with golden 16'h0008 → pass=0.
- Feedback: SEED=16'h8000, VEC_LENGTH=1, valid 7'h00 → signature=16'h100B; golden 16'h100B → pass=1.
- Gapped stream: VEC_LENGTH=8 default SEED, valids with 1–5 idle cycles between → signature equals zero-gap run; vec_count=8; resp_valid in DONE does not change signature.
- Watchdog: TIMEOUT=16, start then 3 valids then silence → done=1, timeout=1, pass=0, vec_count=3 exactly 16 cycles after last valid.
- Restart: start pulsed with resp_valid=1 during RUN after 4 vectors → signature=SEED, vec_count=0, that vector discarded; full run then passes.
